// File: rtl/mod_count_sequencer.sv
// mod_count_sequencer
//   Runs a modulo-MOD counter for a requested number of full passes, then
//   emits a one-cycle done pulse and returns to IDLE.
//
// Parameters
//   counter modulus MOD (2..256)
//   pass-request width PASS_W
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   request a run (sampled only in IDLE, ignored when passes==0)
//   passes    in   number of full passes to run, latched with start
//   pause     in   hold the count while high (RUN -> HOLD)
//   abort     in   cancel the run and return to IDLE (wins over pause)
//   Q         out  current count, 0..MOD-1
//   tc        out  terminal-count strobe (combinational)
//   pass_cnt  out  completed passes in the current/last run
//   busy      out  high in RUN or HOLD
//   done      out  one-cycle completion pulse (DONE state)
module mod_count_sequencer #(
  parameter  int MOD    = 11,
  parameter  int PASS_W = 4,
  localparam int BITS   = $clog2(MOD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PASS_W-1:0] passes,
  input  logic              pause,
  input  logic              abort,
  output logic [BITS-1:0]   Q,
  output logic              tc,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [BITS-1:0] Q_MAX = BITS'(MOD - 1);

  state_t            state_q;
  logic [BITS-1:0]   q_q;
  logic [PASS_W-1:0] pass_cnt_q;
  logic [PASS_W-1:0] pass_tgt_q;
  logic              busy_q;
  logic              done_q;

  logic              at_max;
  logic [PASS_W-1:0] pass_inc;

  assign at_max   = (q_q == Q_MAX);
  // Compared against the target rather than target-1 so a request of
  // 2^PASS_W-1 passes finishes without the target wrapping.
  assign pass_inc = pass_cnt_q + 1'b1;

  assign tc       = (state_q == S_RUN) && at_max && !pause && !abort;
  assign Q        = q_q;
  assign pass_cnt = pass_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      pass_cnt_q <= '0;
      pass_tgt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          // pass_cnt keeps its last value here until a new run is accepted
          if (start && (passes != '0)) begin
            pass_tgt_q <= passes;
            q_q        <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort) begin
            q_q        <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (pause) begin
            // Count is frozen on the entry edge itself
            state_q <= S_HOLD;
          end else if (at_max) begin
            q_q        <= '0;
            pass_cnt_q <= pass_inc;
            if (pass_inc == pass_tgt_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            q_q <= q_q + 1'b1;
          end
        end

        S_HOLD: begin
          if (abort) begin
            q_q        <= '0;
            pass_cnt_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (!pause) begin
            // Resume without counting: the one-cycle bubble
            state_q <= S_RUN;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          q_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_count_sequencer.sv
// Self-checking bench for mod_count_sequencer: a MOD=11 instance driven by a
// table of run scenarios plus directed corner sequences, and a MOD=2 instance
// for the maximum-pass request.
module tb_mod_count_sequencer;
  localparam int MOD = 11;
  localparam int PW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, pause, abort;
  logic [PW-1:0] passes;
  logic [3:0]    Q;
  logic          tc, busy, done;
  logic [PW-1:0] pass_cnt;

  logic          start2, pause2, abort2;
  logic [PW-1:0] passes2;
  logic [0:0]    Q2;
  logic          tc2, busy2, done2;
  logic [PW-1:0] pass_cnt2;

  mod_count_sequencer #(.MOD(MOD), .PASS_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .passes(passes),
    .pause(pause), .abort(abort), .Q(Q), .tc(tc),
    .pass_cnt(pass_cnt), .busy(busy), .done(done)
  );

  mod_count_sequencer #(.MOD(2), .PASS_W(PW)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .passes(passes2),
    .pause(pause2), .abort(abort2), .Q(Q2), .tc(tc2),
    .pass_cnt(pass_cnt2), .busy(busy2), .done(done2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int passes;
    int pause_q;    // Q value at which pause is raised (-1: never)
    int pause_len;  // cycles pause stays high
    int abort_q;    // Q value at which abort is pulsed (-1: never)
    int exp_ndone;
    int exp_done_e; // edges after the start edge at which done is seen
    int exp_tc;
    int exp_pcnt;   // pass_cnt once back in IDLE
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string nm, input vec_t v);
    int e, ndone, done_e, tcs, pause_left, pcnt_done;
    bit paused, aborted, fin;
    e = 0; ndone = 0; done_e = 0; tcs = 0; pause_left = 0; pcnt_done = -1;
    paused = 0; aborted = 0; fin = 0;
    start = 1'b1; passes = PW'(v.passes); pause = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0;
    check({nm, " busy_after_start"}, busy, 1);
    while (!fin && e < 400) begin
      passes = PW'($urandom_range(0, 15));
      pause = 1'b0; abort = 1'b0;
      if (pause_left > 0) begin
        pause = 1'b1; pause_left--;
      end else if (!paused && v.pause_q >= 0 && busy && int'(Q) == v.pause_q) begin
        pause = 1'b1; paused = 1; pause_left = v.pause_len - 1;
      end
      if (!aborted && v.abort_q >= 0 && busy && int'(Q) == v.abort_q) begin
        abort = 1'b1; aborted = 1;
      end
      #1;
      if (tc) tcs++;
      tick();
      e++;
      if (int'(Q) > MOD - 1) check({nm, " q_range"}, Q, MOD - 1);
      if (v.pause_q < 0 && busy) check({nm, " q_seq"}, Q, e % MOD);
      if (done) begin
        ndone++; done_e = e; pcnt_done = int'(pass_cnt);
        check({nm, " q_at_done"}, Q, 0);
        check({nm, " busy_at_done"}, busy, 0);
      end
      if (!busy && !done) fin = 1;
    end
    pause = 1'b0; abort = 1'b0;
    check({nm, " finished_in_time"}, fin, 1);
    check({nm, " done_count"}, ndone, v.exp_ndone);
    check({nm, " done_edge"}, done_e, v.exp_done_e);
    check({nm, " tc_count"}, tcs, v.exp_tc);
    if (v.exp_ndone > 0) check({nm, " pass_cnt_at_done"}, pcnt_done, v.passes);
    check({nm, " idle_q"}, Q, 0);
    check({nm, " idle_pass_cnt"}, pass_cnt, v.exp_pcnt);
    $display("case %s: passes=%0d done_edge=%0d dones=%0d tcs=%0d pass_cnt=%0d",
             nm, v.passes, done_e, ndone, tcs, pass_cnt);
  endtask

  vec_t tbl[8];
  vec_t restart;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad, nd, de, pc, i;

    tbl[0] = '{2, -1, 0, -1, 1, 22, 2, 2};   // basic two-pass run
    tbl[1] = '{1,  5, 3, -1, 1, 15, 1, 1};   // 3-cycle pause at Q=5
    tbl[2] = '{1, -1, 0, -1, 1, 11, 1, 1};   // single pass reference
    tbl[3] = '{1, -1, 0,  7, 0,  0, 0, 0};   // abort at Q=7
    tbl[4] = '{3, 10, 1, -1, 1, 35, 3, 3};   // pause on terminal count
    tbl[5] = '{2, -1, 0,  3, 0,  0, 0, 0};   // abort early in pass 0
    tbl[6] = '{15, -1, 0, -1, 1, 165, 15, 15}; // max request on MOD=11
    tbl[7] = '{2,  0, 2, -1, 1, 25, 2, 2};   // pause right after start

    reset = 1'b1; start = 1'b0; passes = '0; pause = 1'b0; abort = 1'b0;
    start2 = 1'b0; passes2 = '0; pause2 = 1'b0; abort2 = 1'b0;
    tick(); tick();
    check("reset q", Q, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass_cnt", pass_cnt, 0);
    check("reset tc", tc, 0);
    reset = 1'b0;
    tick();
    check("idle tc", tc, 0);
    $display("reset: q=%0d busy=%0d done=%0d pass_cnt=%0d", Q, busy, done, pass_cnt);

    for (int k = 0; k < 8; k++) run_case($sformatf("tbl%0d", k), tbl[k]);

    // start with passes=0 is ignored
    start = 1'b1; passes = '0;
    tick();
    start = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (busy || done) bad++;
    end
    check("zero_passes busy_or_done_cycles", bad, 0);
    $display("zero passes: cycles with busy/done=%0d", bad);

    // start re-pulsed mid-run with passes=9 must not change the target
    start = 1'b1; passes = PW'(1);
    tick();
    nd = 0; de = 0; pc = -1;
    for (int e = 1; e <= 30; e++) begin
      start = (e == 4);
      passes = PW'(9);
      tick();
      if (done) begin nd++; de = e; pc = int'(pass_cnt); end
    end
    start = 1'b0;
    check("restart_ignored done_count", nd, 1);
    check("restart_ignored done_edge", de, 11);
    check("restart_ignored pass_cnt", pc, 1);
    $display("restart during run: dones=%0d edge=%0d pass_cnt=%0d", nd, de, pc);

    // reset pulsed while in HOLD, then a fresh run completes
    start = 1'b1; passes = PW'(2);
    tick();
    start = 1'b0;
    i = 0;
    while (Q != 4'd4 && i < 20) begin tick(); i++; end
    check("hold_reach_q4", Q, 4);
    pause = 1'b1;
    tick();
    check("hold q", Q, 4);
    check("hold busy", busy, 1);
    tick();
    check("hold q second", Q, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0; pause = 1'b0;
    check("reset_in_hold q", Q, 0);
    check("reset_in_hold pass_cnt", pass_cnt, 0);
    check("reset_in_hold busy", busy, 0);
    bad = 0;
    repeat (15) begin
      tick();
      if (done || busy) bad++;
    end
    check("reset_in_hold no_done", bad, 0);
    $display("reset in hold: q=%0d pass_cnt=%0d stray=%0d", Q, pass_cnt, bad);
    restart = '{1, -1, 0, -1, 1, 11, 1, 1};
    run_case("after_reset", restart);

    // abort and pause together in RUN: abort wins
    start = 1'b1; passes = PW'(1);
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    check("abort_pause busy", busy, 0);
    check("abort_pause q", Q, 0);
    tick();
    check("abort_pause stays_idle", busy, 0);
    $display("abort+pause: busy=%0d q=%0d", busy, Q);

    // abort while in HOLD
    start = 1'b1; passes = PW'(3);
    tick();
    start = 1'b0;
    tick(); tick();
    pause = 1'b1;
    tick(); tick();
    check("abort_hold busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    check("abort_hold busy", busy, 0);
    check("abort_hold q", Q, 0);
    check("abort_hold pass_cnt", pass_cnt, 0);
    check("abort_hold done", done, 0);
    $display("abort in hold: busy=%0d q=%0d pass_cnt=%0d", busy, Q, pass_cnt);

    // maximum request of 15 passes on the MOD=2 instance
    start2 = 1'b1; passes2 = PW'(15);
    tick();
    start2 = 1'b0;
    nd = 0; de = 0; pc = -1; bad = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 29) check("mod2 pass_cnt_before_last", pass_cnt2, 14);
      if (done2) begin nd++; de = e; pc = int'(pass_cnt2); end
    end
    check("mod2 done_count", nd, 1);
    check("mod2 done_edge", de, 30);
    check("mod2 pass_cnt_at_done", pc, 15);
    check("mod2 idle_pass_cnt", pass_cnt2, 15);
    check("mod2 idle_busy", busy2, 0);
    $display("mod2 max: dones=%0d edge=%0d pass_cnt=%0d", nd, de, pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
